// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl: clocked load/store bus with region decode, wait states, faults and an IO output bank.
// Map by addr[31:28]: 0 TEXT, 1 DATA, 2 IO, other CSR; optional cycle CSR via DATA_BUS_CYCLE_CSR_EN.
module data_bus_ctrl #(
    parameter int IO_CHANNELS = 4,
    parameter int IO_WIDTH    = 8,
    parameter int RAM_LAT     = 1,
    parameter int FLASH_LAT   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req,
    input  logic                            rw,
    input  logic [1:0]                      len,
    input  logic [31:0]                     addr,
    input  logic [31:0]                     write,
    output logic [31:0]                     read,
    output logic                            ready,
    output logic                            exception,
    output logic [31:0]                     mem_addr,
    output logic [1:0]                      mem_len,
    output logic [31:0]                     mem_wdata,
    output logic                            ram_we,
    input  logic [31:0]                     read_ram,
    input  logic                            exception_ram,
    input  logic [31:0]                     read_flash,
    input  logic                            exception_flash,
    output logic [IO_CHANNELS*IO_WIDTH-1:0] io_out
);
    localparam int IW = (IO_CHANNELS > 1) ? $clog2(IO_CHANNELS) : 1;
    localparam logic [3:0] TEXT_TOKEN = 4'h0, DATA_TOKEN = 4'h1, IO_TOKEN = 4'h2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                r_state, w_next;
    logic                  r_rw, r_exc;
    logic [1:0]            r_len;
    logic [3:0]            r_cnt, w_lat;
    logic [31:0]           r_addr, r_wdata, r_read;
    logic [IO_WIDTH-1:0]   r_io [IO_CHANNELS];
    logic                  w_idle, w_rw, w_text, w_data, w_io, w_csr;
    logic                  w_fault, w_exc, w_to_done, w_csr_fault;
    logic [1:0]            w_len;
    logic [31:0]           w_a, w_rdata, w_io_rd, w_csr_rd;

`ifdef DATA_BUS_CYCLE_CSR_EN
    logic [31:0] r_cyc;
    always_ff @(posedge clk) r_cyc <= rst ? 32'd0 : r_cyc + 32'd1;
    assign w_csr_fault = w_rw | (w_len != 2'd2);
    assign w_csr_rd    = r_cyc;
`else
    assign w_csr_fault = 1'b1;
    assign w_csr_rd    = 32'd0;
`endif

    // In IDLE the decode looks at the live request, afterwards at the latched copy
    always_comb begin
        w_idle    = r_state == S_IDLE;
        w_a       = w_idle ? addr : r_addr;
        w_rw      = w_idle ? rw : r_rw;
        w_len     = w_idle ? len : r_len;
        w_text    = w_a[31:28] == TEXT_TOKEN;
        w_data    = w_a[31:28] == DATA_TOKEN;
        w_io      = w_a[31:28] == IO_TOKEN;
        w_csr     = ~(w_text | w_data | w_io);
        w_lat     = w_text ? 4'(FLASH_LAT) : w_data ? 4'(RAM_LAT) : 4'd0;
        w_fault   = (w_len == 2'd3) | (w_len == 2'd1 & w_a[0]) | (w_len == 2'd2 & w_a[1:0] != 2'd0)
                  | (w_text & w_rw) | (w_io & ((w_a[27:2] >= 26'(IO_CHANNELS)) | (w_len != 2'd2)))
                  | (w_csr & w_csr_fault);
        w_exc     = w_fault | (w_data & exception_ram) | (w_text & exception_flash);
        w_io_rd   = 32'(r_io[w_a[IW+1:2]]);
        w_rdata   = (w_exc | w_rw) ? 32'd0 : w_data ? read_ram : w_text ? read_flash
                  : w_io ? w_io_rd : w_csr_rd;
        w_to_done = (w_idle & req & (w_fault | w_lat == 4'd0)) | (r_state == S_WAIT & r_cnt == 4'd1);
    end

    always_comb begin
        w_next = w_to_done ? S_DONE : (w_idle & req) ? S_WAIT : (r_state == S_DONE) ? S_IDLE : r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rw    <= 1'b0;
            r_len   <= 2'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_cnt   <= 4'd0;
            r_read  <= 32'd0;
            r_exc   <= 1'b0;
            for (int i = 0; i < IO_CHANNELS; i++) r_io[i] <= '0;
        end else begin
            r_state <= w_next;
            if (w_idle & req) begin
                r_rw    <= rw;
                r_len   <= len;
                r_addr  <= addr;
                r_wdata <= write;
                r_cnt   <= w_lat;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_to_done) begin
                r_read <= w_rdata;
                r_exc  <= w_exc;
            end
            if (r_state == S_DONE && w_io && r_rw && !r_exc) r_io[w_a[IW+1:2]] <= r_wdata[IO_WIDTH-1:0];
        end
    end

    always_comb begin
        ready  = r_state == S_DONE;
        ram_we = (r_state == S_DONE) & w_data & r_rw & ~r_exc;
    end

    assign read      = r_read;
    assign exception = r_exc;
    assign mem_addr  = r_addr;
    assign mem_len   = r_len;
    assign mem_wdata = r_wdata;

    for (genvar i = 0; i < IO_CHANNELS; i++) begin : g_io
        assign io_out[i*IO_WIDTH +: IO_WIDTH] = r_io[i];
    end
endmodule

// File: doc/data_bus_ctrl.md
Name: data_bus_ctrl

Overview:
- Clocked, parametrised successor to the combinational core data bus.
- Accepts one load/store per request/ready handshake and decodes the address into DATA (RAM), TEXT (flash), IO and CSR regions using the `memory_map.v` range/token macros.
- Adds per-region wait states, alignment and permission faults, and an N-channel registered IO output bank. Channel 0 drives the board LEDs.
- Sits between the core load/store unit and the ram/flash instances.

Parameters:
- IO_CHANNELS, 4, number of IO output registers; register i lives at IO base + 4*i.
- IO_WIDTH, 8, width of each IO output register.
- RAM_LAT, 1, wait cycles inserted for DATA-region accesses (0..15).
- FLASH_LAT, 2, wait cycles inserted for TEXT-region accesses (0..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  1  request; sampled only in IDLE
- rw  in  1  1 = write, 0 = read
- len  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- addr  in  32  byte address
- write  in  32  store data, right-aligned
- read  out  32  load data, valid when ready = 1
- ready  out  1  one-cycle completion pulse
- exception  out  1  fault flag, valid when ready = 1
- mem_addr  out  32  latched address to ram/flash
- mem_len  out  2  latched len to ram
- mem_wdata  out  32  latched store data to ram
- ram_we  out  1  one-cycle RAM write commit
- read_ram  in  32  RAM read data
- exception_ram  in  1  RAM fault
- read_flash  in  32  flash read data
- exception_flash  in  1  flash fault
- io_out  out  IO_CHANNELS*IO_WIDTH  IO registers; channel i occupies bits [i*IO_WIDTH +: IO_WIDTH]

Behaviour:
- Reset (synchronous, sampled at the clk edge, active-high): state = IDLE; read, ready, exception, ram_we, io_out, mem_addr, mem_len and mem_wdata all 0; wait counter 0. Reset in any state abandons the transaction: no ready, no write commit.
- FSM states are IDLE, WAIT and DONE.
- IDLE:
  - When req = 1, latch rw, len, addr and write, decode the region, evaluate faults, and load the counter with the region latency (DATA = RAM_LAT, TEXT = FLASH_LAT, IO/CSR = 0).
  - Go to WAIT if the latency is nonzero and there is no fault; otherwise go to DONE.
- WAIT: decrement the counter each cycle; when it reaches 1, go to DONE.
- DONE:
  - ready = 1 for exactly one cycle; read and exception are registered on entry to DONE.
  - Then go to IDLE unconditionally. A req held high is re-accepted in that IDLE cycle, so the master must drop req on the ready cycle.
- Latency: ready is asserted in cycle N+1+LAT, where N is the cycle in which req is sampled. A faulting request always completes in N+1.
- Faults (exception = 1, read = 0, no side effects):
  - len = 3.
  - Misalignment: half with addr[0] = 1; word with addr[1:0] != 0.
  - Any write to TEXT.
  - IO index >= IO_CHANNELS, or IO access with len != 2.
  - exception_ram / exception_flash sampled at entry to DONE.
- Address that matches no region: treated as CSR.
- DATA write: ram_we = 1 only during the DONE cycle, and only if the request has no fault.
- DATA read: read = read_ram, captured on the cycle the FSM enters DONE.
- TEXT read: read = read_flash, captured on the cycle the FSM enters DONE.
- IO write: io_out channel i ← write[IO_WIDTH-1:0] on the DONE cycle; all other channels are unchanged.
- IO read: returns channel i zero-extended to 32 bits.
- CSR (without the optional feature): read returns 0, exception = 1.
- req while in WAIT or DONE: ignored.
- mem_addr, mem_len and mem_wdata are held stable from the IDLE latch through DONE.

Optional Feature:
- Macro: DATA_BUS_CYCLE_CSR_EN.
- When defined: a 32-bit free-running cycle counter is cleared by rst and increments every clk, wrapping 0xFFFFFFFF → 0. A word read of the CSR region returns the counter value sampled at entry to DONE, with exception = 0. CSR writes return exception = 1.
- When undefined: no counter is built, and all CSR accesses fault as described in Behaviour.

Test Plan:
- Word write 0x000000A5 to IO base + 0 (channel 0), then word read of the same address → io_out[7:0] = 0xA5 after the write's DONE cycle; the read returns 0x000000A5; ready arrives 1 cycle after each req; other channels stay 0.
- DATA word write 0xDEADBEEF then read with RAM_LAT = 1 → ram_we pulses once in the write's DONE cycle; ready at N+2; read = 0xDEADBEEF.
- Half read at DATA base + 1 → ready at N+1, exception = 1, ram_we never asserted.
- Word write to TEXT base → exception = 1; flash read at the same address (FLASH_LAT = 2) returns flash data with ready at N+3.
- rst asserted during WAIT of a DATA write → no ready, no ram_we, io_out = 0, FSM in IDLE the next cycle and accepts a new req.
- With DATA_BUS_CYCLE_CSR_EN defined, two CSR word reads 10 cycles apart → returned values differ by 10, with exception = 0 on both.
